ddr_gray_pointer: RTL and testbench

Parametrised Gray-coded FIFO pointer for the DDR wishbone slave's clock-crossing FIFOs. It generalises the fixed-width Gray counter in four ways: a configurable pointer width with a wrap bit, a write or read mode, a built-in synchronizer for the opposite-domain pointer, and registered full or empty detection. One instance sits on each side of every async FIFO.

---
 rtl/ddr_gray_pkg.sv | 37 +++
 rtl/ddr_gray_sync.sv | 35 +++
 rtl/ddr_gray_pointer.sv | 153 +++++++++++++++
 tb/tb_ddr_gray_pointer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_gray_pkg.sv
// ---------------------------------------------------------------------------
// ddr_gray_pkg
// Shared helpers for the Gray-coded clock-crossing pointers.
//   PTR_MODE_WRITE / PTR_MODE_READ : pointer side selectors
//   GRAY_MAX_W                     : widest pointer the helpers handle
//   bin2gray / gray2bin            : width-generic conversions. Callers
//                                    zero-extend to GRAY_MAX_W and truncate
//                                    the result back to their own width.
//                                    Zero upper bits make this exact for any
//                                    width up to GRAY_MAX_W.
// ---------------------------------------------------------------------------
package ddr_gray_pkg;

    localparam int PTR_MODE_WRITE = 0;
    localparam int PTR_MODE_READ  = 1;
    localparam int GRAY_MAX_W     = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down: each binary bit is the XOR of all Gray
    // bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] gray
    );
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ddr_gray_sync.sv
// ---------------------------------------------------------------------------
// ddr_gray_sync
// Multi-flop synchronizer chain for a Gray-coded (single-bit-change) bus.
// Parameters:
//   WIDTH  : bus width
//   STAGES : flop stages, >= 2
// Ports:
//   Clk      in            destination clock
//   Rst      in            asynchronous active-high reset, chain clears to 0
//   Data_in  in  [WIDTH]   unsynchronized source-domain bus
//   Data_out out [WIDTH]   synchronized bus, STAGES Clk edges later
// ---------------------------------------------------------------------------
module ddr_gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], Data_in};
        end
    end

    assign Data_out = r_chain[STAGES-1];

endmodule

// File: rtl/ddr_gray_pointer.sv
// ---------------------------------------------------------------------------
// ddr_gray_pointer
// Gray-coded async-FIFO pointer with wrap bit, remote-pointer synchronizer
// and registered full (write side) or empty (read side) flag.
// Optional macro DDR_GRAY_PTR_LEVEL_EN adds fill level and almost flag.
// Parameters:
//   ADDR_WIDTH    : FIFO address bits, depth = 2**ADDR_WIDTH, >= 2
//   SYNC_STAGES   : remote-pointer synchronizer depth, >= 2
//   PTR_MODE      : 0 = write side (flag = full), 1 = read side (flag = empty)
//   ALMOST_THRESH : almost-flag margin (level build only)
// Ports:
//   Clk           in         sole clock
//   Rst           in         asynchronous active-high reset
//   Clear_in      in         synchronous pointer clear, beats Inc_in
//   Inc_in        in         request to advance the pointer
//   RemoteGray_in in  [A+1]  opposite-domain Gray pointer, unsynchronized
//   Ack_out       out        combinational, increment accepted this cycle
//   GrayPtr_out   out [A+1]  registered Gray pointer to the other domain
//   BinPtr_out    out [A+1]  registered binary pointer
//   Addr_out      out [A]    RAM address
//   Flag_out      out        registered full / empty
//   Level_out     out [A+1]  fill level (macro only)
//   Almost_out    out        almost-full / almost-empty (macro only)
// ---------------------------------------------------------------------------
module ddr_gray_pointer
    import ddr_gray_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int PTR_MODE      = 0,
    parameter int ALMOST_THRESH = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clear_in,
    input  logic                  Inc_in,
    input  logic [ADDR_WIDTH:0]   RemoteGray_in,
    output logic                  Ack_out,
    output logic [ADDR_WIDTH:0]   GrayPtr_out,
    output logic [ADDR_WIDTH:0]   BinPtr_out,
    output logic [ADDR_WIDTH-1:0] Addr_out,
    output logic                  Flag_out
`ifdef DDR_GRAY_PTR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   Level_out,
    output logic                  Almost_out
`endif
);

    localparam int   PW       = ADDR_WIDTH + 1;
    localparam bit   IS_READ  = (PTR_MODE == PTR_MODE_READ);
    // Read side idles empty, write side idles not-full.
    localparam logic FLAG_RST = IS_READ;

    if (ADDR_WIDTH < 2 || SYNC_STAGES < 2 ||
        (PTR_MODE != PTR_MODE_WRITE && PTR_MODE != PTR_MODE_READ) ||
        ALMOST_THRESH < 0 || ALMOST_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_params
        $error("ddr_gray_pointer: illegal parameter combination");
    end

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_flag;
    logic [PW-1:0] w_rsync;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_full_match;
    logic          w_ack;
    logic          w_flag_next;

    ddr_gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .Data_in  (RemoteGray_in),
        .Data_out (w_rsync)
    );

    assign w_ack       = Inc_in & ~r_flag & ~Clear_in;
    assign w_bin_next  = r_bin + {{(PW-1){1'b0}}, w_ack};
    assign w_gray_next = PW'(bin2gray(GRAY_MAX_W'(w_bin_next)));

    // Full when the local pointer is exactly one lap ahead of the remote one:
    // in Gray code that is the remote value with its top two bits inverted.
    assign w_full_match = {~w_rsync[ADDR_WIDTH -: 2], w_rsync[ADDR_WIDTH-2:0]};

    // Flags compare the next local pointer against the current synchronized
    // remote pointer, so a local increment shows up on the same edge while
    // remote movement is only ever seen late (conservative).
    assign w_flag_next = IS_READ ? (w_gray_next == w_rsync)
                                 : (w_gray_next == w_full_match);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_flag <= FLAG_RST;
        end else if (Clear_in) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_flag <= FLAG_RST;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_flag <= w_flag_next;
        end
    end

    assign Ack_out     = w_ack;
    assign GrayPtr_out = r_gray;
    assign BinPtr_out  = r_bin;
    assign Addr_out    = r_bin[ADDR_WIDTH-1:0];
    assign Flag_out    = r_flag;

`ifdef DDR_GRAY_PTR_LEVEL_EN
    localparam logic [PW-1:0] FULL_THR  = PW'((1 << ADDR_WIDTH) - ALMOST_THRESH);
    localparam logic [PW-1:0] EMPTY_THR = PW'(ALMOST_THRESH);
    localparam logic          ALM_RST   = IS_READ;

    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic          w_almost_next;
    logic [PW-1:0] r_level;
    logic          r_almost;

    assign w_rbin = PW'(gray2bin(GRAY_MAX_W'(w_rsync)));

    // Modulo-2^PW subtraction gives the occupancy directly thanks to the
    // wrap bit; the result never exceeds the depth.
    assign w_level_next  = IS_READ ? (w_rbin - w_bin_next) : (w_bin_next - w_rbin);
    assign w_almost_next = IS_READ ? (w_level_next <= EMPTY_THR)
                                   : (w_level_next >= FULL_THR);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_level  <= '0;
            r_almost <= ALM_RST;
        end else if (Clear_in) begin
            r_level  <= '0;
            r_almost <= ALM_RST;
        end else begin
            r_level  <= w_level_next;
            r_almost <= w_almost_next;
        end
    end

    assign Level_out  = r_level;
    assign Almost_out = r_almost;
`endif

endmodule

// File: tb/tb_ddr_gray_pointer.sv
// ---------------------------------------------------------------------------
// tb_ddr_gray_pointer
// Directed bench for ddr_gray_pointer with ADDR_WIDTH=2, SYNC_STAGES=2.
// One write-side and one read-side instance. Level/almost checks are built
// only when DDR_GRAY_PTR_LEVEL_EN is defined.
// ---------------------------------------------------------------------------
module tb_ddr_gray_pointer;

    localparam int AW = 2;
    localparam int PW = AW + 1;

    logic Clk    = 1'b0;
    logic clk_en = 1'b0;
    logic Rst    = 1'b0;

    logic          wr_clr = 1'b0, wr_inc = 1'b0;
    logic [PW-1:0] wr_rg  = '0;
    logic          wr_ack, wr_flag;
    logic [PW-1:0] wr_gray, wr_bin;
    logic [AW-1:0] wr_addr;

    logic          rd_clr = 1'b0, rd_inc = 1'b0;
    logic [PW-1:0] rd_rg  = '0;
    logic          rd_ack, rd_flag;
    logic [PW-1:0] rd_gray, rd_bin;
    logic [AW-1:0] rd_addr;

`ifdef DDR_GRAY_PTR_LEVEL_EN
    logic [PW-1:0] wr_level, rd_level;
    logic          wr_almost, rd_almost;
`endif

    int checks = 0;
    int errors = 0;

    initial forever begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    ddr_gray_pointer #(
        .ADDR_WIDTH(AW), .SYNC_STAGES(2), .PTR_MODE(0), .ALMOST_THRESH(1)
    ) u_wr (
        .Clk(Clk), .Rst(Rst), .Clear_in(wr_clr), .Inc_in(wr_inc),
        .RemoteGray_in(wr_rg), .Ack_out(wr_ack), .GrayPtr_out(wr_gray),
        .BinPtr_out(wr_bin), .Addr_out(wr_addr), .Flag_out(wr_flag)
`ifdef DDR_GRAY_PTR_LEVEL_EN
        , .Level_out(wr_level), .Almost_out(wr_almost)
`endif
    );

    ddr_gray_pointer #(
        .ADDR_WIDTH(AW), .SYNC_STAGES(2), .PTR_MODE(1), .ALMOST_THRESH(1)
    ) u_rd (
        .Clk(Clk), .Rst(Rst), .Clear_in(rd_clr), .Inc_in(rd_inc),
        .RemoteGray_in(rd_rg), .Ack_out(rd_ack), .GrayPtr_out(rd_gray),
        .BinPtr_out(rd_bin), .Addr_out(rd_addr), .Flag_out(rd_flag)
`ifdef DDR_GRAY_PTR_LEVEL_EN
        , .Level_out(rd_level), .Almost_out(rd_almost)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          clr;
        logic          inc;
        logic [PW-1:0] rg;
        logic          ack;
        logic [PW-1:0] gray;
        logic [PW-1:0] bin;
        logic          flag;
    } vec_t;

    vec_t          vecs[11];
    logic [PW-1:0] wrap_exp[8];
    logic [PW-1:0] dly[4];
    logic [PW-1:0] prev;
    logic          a;
    int            k;

    initial begin
        // write side, remote held at 000: fill, clear from full, refill to 3,
        // clear together with inc, then idle
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 3'b001, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b011, 3'b010, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b010, 3'b011, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b110, 3'b100, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b110, 3'b100, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 3'b001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b011, 3'b010, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b010, 3'b011, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
        wrap_exp = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        // reset with the clock stopped
        #1 Rst = 1'b1;
        #1;
        chk("rst_wr_gray", wr_gray, 0);
        chk("rst_wr_bin",  wr_bin,  0);
        chk("rst_wr_flag", wr_flag, 0);
        chk("rst_rd_gray", rd_gray, 0);
        chk("rst_rd_bin",  rd_bin,  0);
        chk("rst_rd_flag", rd_flag, 1);
`ifdef DDR_GRAY_PTR_LEVEL_EN
        chk("rst_wr_level",  wr_level,  0);
        chk("rst_wr_almost", wr_almost, 0);
        chk("rst_rd_level",  rd_level,  0);
        chk("rst_rd_almost", rd_almost, 1);
`endif
        #2 Rst = 1'b0;
        clk_en = 1'b1;
        @(posedge Clk); #1;

        // table-driven write-side sequence
        for (int i = 0; i < 11; i++) begin
            wr_clr = vecs[i].clr;
            wr_inc = vecs[i].inc;
            wr_rg  = vecs[i].rg;
            #1;
            chk($sformatf("vec%0d_ack", i), wr_ack, vecs[i].ack);
            @(posedge Clk); #1;
            chk($sformatf("vec%0d_gray", i), wr_gray, vecs[i].gray);
            chk($sformatf("vec%0d_bin",  i), wr_bin,  vecs[i].bin);
            chk($sformatf("vec%0d_addr", i), wr_addr, vecs[i].bin[AW-1:0]);
            chk($sformatf("vec%0d_flag", i), wr_flag, vecs[i].flag);
        end

`ifdef DDR_GRAY_PTR_LEVEL_EN
        // level/almost on the write side, remote still 000, threshold 1
        wr_inc = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge Clk); #1;
            chk($sformatf("lvl%0d_level", i),  wr_level,  i);
            chk($sformatf("lvl%0d_almost", i), wr_almost, (i >= 3) ? 1 : 0);
            chk($sformatf("lvl%0d_flag", i),   wr_flag,   (i == 4) ? 1 : 0);
        end
        wr_inc = 1'b0;
        wr_clr = 1'b1;
        @(posedge Clk); #1;
        wr_clr = 1'b0;
        chk("lvl_clr_level", wr_level, 0);
`endif

        // wrap: remote follows the local Gray pointer with a 4-cycle lag
        for (int i = 0; i < 4; i++) dly[i] = '0;
        prev = '0;
        k = 0;
        wr_inc = 1'b1;
        for (int c = 0; c < 100 && k < 8; c++) begin
            wr_rg = dly[3];
            #1;
            a = wr_ack;
            @(posedge Clk); #1;
            dly[3] = dly[2];
            dly[2] = dly[1];
            dly[1] = dly[0];
            dly[0] = wr_gray;
            if (a) begin
                chk($sformatf("wrap%0d_gray", k), wr_gray, wrap_exp[k]);
                chk($sformatf("wrap%0d_onebit", k), $countones(wr_gray ^ prev), 1);
                prev = wr_gray;
                k++;
            end
        end
        wr_inc = 1'b0;
        chk("wrap_count", k, 8);
        chk("wrap_bin", wr_bin, 0);

        // read side: inc while empty is ignored
        rd_inc = 1'b1;
        #1;
        chk("drain_ign_ack", rd_ack, 0);
        @(posedge Clk); #1;
        chk("drain_ign_bin",  rd_bin,  0);
        chk("drain_ign_flag", rd_flag, 1);

        // remote moves to binary 2; empty releases on the 3rd edge
        rd_inc = 1'b0;
        rd_rg  = 3'b011;
        @(posedge Clk); #1;
        chk("drain_e1_flag", rd_flag, 1);
        @(posedge Clk); #1;
        chk("drain_e2_flag", rd_flag, 1);
        @(posedge Clk); #1;
        chk("drain_e3_flag", rd_flag, 0);
`ifdef DDR_GRAY_PTR_LEVEL_EN
        chk("drain_e3_level",  rd_level,  2);
        chk("drain_e3_almost", rd_almost, 0);
`endif
        rd_inc = 1'b1;
        #1;
        chk("drain_r1_ack", rd_ack, 1);
        @(posedge Clk); #1;
        chk("drain_r1_gray", rd_gray, 3'b001);
        chk("drain_r1_flag", rd_flag, 0);
`ifdef DDR_GRAY_PTR_LEVEL_EN
        chk("drain_r1_level",  rd_level,  1);
        chk("drain_r1_almost", rd_almost, 1);
`endif
        #1;
        chk("drain_r2_ack", rd_ack, 1);
        @(posedge Clk); #1;
        chk("drain_r2_gray", rd_gray, 3'b011);
        chk("drain_r2_bin",  rd_bin,  3'b010);
        chk("drain_r2_flag", rd_flag, 1);
`ifdef DDR_GRAY_PTR_LEVEL_EN
        chk("drain_r2_level", rd_level, 0);
`endif
        #1;
        chk("drain_r3_ack", rd_ack, 0);
        @(posedge Clk); #1;
        chk("drain_r3_bin", rd_bin, 3'b010);
        rd_inc = 1'b0;

        // reset mid-operation with the clock stopped
        @(negedge Clk);
        clk_en = 1'b0;
        #2 Rst = 1'b1;
        #1;
        chk("mrst_rd_bin",  rd_bin,  0);
        chk("mrst_rd_gray", rd_gray, 0);
        chk("mrst_rd_addr", rd_addr, 0);
        chk("mrst_rd_flag", rd_flag, 1);
        chk("mrst_wr_bin",  wr_bin,  0);
        chk("mrst_wr_flag", wr_flag, 0);
        #2 Rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
